// File: rtl/s2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : s2_pkg                                                    |
// | Purpose  : Shared types and default sizes for the s2 serial-to-RB2   |
// |            frame loader (FSM state encoding, frame geometry).        |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package s2_pkg;

  localparam int DEF_DATA_W = 18;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_FRAMES = 8;
  localparam int FRAME_BITS = DEF_ADDR_W + DEF_DATA_W;

  // Bit counter width; wide enough to hold FRAME_BITS (21) and saturate there.
  localparam int BITCNT_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage : s2_pkg
`default_nettype wire

// File: rtl/s2_deser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : s2_deser                                                  |
// | Purpose  : Serial frame deserializer: MSB-first shift register plus  |
// |            saturating bit counter.                                   |
// | Ports    : clk, rst      - clock / sync active-high reset            |
// |            shift         - shift sd in this cycle                    |
// |            restart       - this bit is the first of a new frame      |
// |            sd            - serial data                               |
// |            last_bit      - counter one short of a full frame         |
// |            frame_full    - full frame captured                       |
// |            addr, data    - captured frame fields                     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module s2_deser
  import s2_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift,
  input  logic              restart,
  input  logic              sd,
  output logic              last_bit,
  output logic              frame_full,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam int NB = ADDR_W + DATA_W;
  localparam logic [BITCNT_W-1:0] NB_C = BITCNT_W'(NB);

  logic [NB-1:0]       sr;
  logic [BITCNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift) begin
      sr <= {sr[NB-2:0], sd};
      if (restart)
        cnt <= BITCNT_W'(1);
      else if (cnt != NB_C)
        cnt <= cnt + BITCNT_W'(1);
    end
  end

  // Address occupies the first-received (upper) bits of the frame.
  assign addr       = sr[NB-1:DATA_W];
  assign data       = sr[DATA_W-1:0];
  assign frame_full = (cnt == NB_C);
  assign last_bit   = (cnt == NB_C - BITCNT_W'(1));

endmodule : s2_deser
`default_nettype wire

// File: rtl/s2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : s2                                                        |
// | Purpose  : Receives FRAMES serial frames (address + data, MSB first) |
// |            and writes each into the RB2 RAM, then flags done.        |
// | Ports    : clk, rst      - clock / sync active-high reset            |
// |            sen, sd       - serial enable (active low) and data       |
// |            RB2_RW/A/D    - RB2 write strobe (low = write), addr, data|
// |            RB2_Q         - RB2 read data (not used)                  |
// |            S2_done       - all frames written                        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module s2
  import s2_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int FRAMES = DEF_FRAMES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sen,
  input  logic              sd,
  output logic              RB2_RW,
  output logic [ADDR_W-1:0] RB2_A,
  output logic [DATA_W-1:0] RB2_D,
  input  logic [DATA_W-1:0] RB2_Q,
  output logic              S2_done
);

  localparam int FC_W = $clog2(FRAMES + 1);
  localparam logic [FC_W-1:0] LAST_FRAME = FC_W'(FRAMES - 1);

  state_t            state, next_state;
  logic [FC_W-1:0]   frame_cnt;
  logic [ADDR_W-1:0] a_hold;
  logic [DATA_W-1:0] d_hold;
  logic              shift, restart, last_bit, frame_full, wr;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;

  // Read port is never used by this block.
  logic unused_q;
  assign unused_q = ^RB2_Q;

  s2_deser #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_deser (
    .clk        (clk),
    .rst        (rst),
    .shift      (shift),
    .restart    (restart),
    .sd         (sd),
    .last_bit   (last_bit),
    .frame_full (frame_full),
    .addr       (cap_addr),
    .data       (cap_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      frame_cnt <= '0;
      a_hold    <= '0;
      d_hold    <= '0;
    end else begin
      state <= next_state;
      if (wr) begin
        frame_cnt <= frame_cnt + FC_W'(1);
        a_hold    <= cap_addr;
        d_hold    <= cap_data;
      end
    end
  end

  always_comb begin
    next_state = state;
    shift      = 1'b0;
    restart    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!sen) begin
          shift      = 1'b1;
          restart    = 1'b1;
          next_state = ST_RECV;
        end
      end
      ST_RECV: begin
        if (sen) begin
          next_state = ST_IDLE;          // short frame: dropped
        end else begin
          shift = 1'b1;
          // Enter WRITE on the same edge that captures the final bit.
          if (last_bit)
            next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (frame_cnt == LAST_FRAME)
          next_state = ST_DONE;
        else if (sen)
          next_state = ST_IDLE;
        else
          next_state = ST_FLUSH;         // frame still running: over-length
      end
      ST_FLUSH: begin
        if (sen)
          next_state = ST_IDLE;
      end
      ST_DONE: begin
        next_state = ST_DONE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // During WRITE the shift register is frozen on the complete frame, so it
  // drives the RB2 bus directly; the hold registers keep it stable afterwards.
  assign wr      = (state == ST_WRITE) && frame_full;
  assign RB2_RW  = ~wr;
  assign RB2_A   = wr ? cap_addr : a_hold;
  assign RB2_D   = wr ? cap_data : d_hold;
  assign S2_done = (state == ST_DONE);

endmodule : s2
`default_nettype wire

// File: tb/tb_s2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_s2                                                     |
// | Purpose  : Self-checking bench for s2 with a write scoreboard.       |
// | Ports    : none                                                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_s2;

  logic        clk = 1'b0;
  logic        rst;
  logic        sen;
  logic        sd;
  logic        RB2_RW;
  logic [2:0]  RB2_A;
  logic [17:0] RB2_D;
  logic [17:0] RB2_Q;
  logic        S2_done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [2:0]  addr;
    logic [17:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [17:0] mem [8];

  s2 dut (
    .clk     (clk),
    .rst     (rst),
    .sen     (sen),
    .sd      (sd),
    .RB2_RW  (RB2_RW),
    .RB2_A   (RB2_A),
    .RB2_D   (RB2_D),
    .RB2_Q   (RB2_Q),
    .S2_done (S2_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write cycle must match the next scoreboard entry.
  always @(negedge clk) begin
    if (RB2_RW !== 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got RW=%b A=%0d D=%h at cyc %0d, required no write",
                 RB2_RW, RB2_A, RB2_D, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (RB2_A !== e.addr || RB2_D !== e.data || cyc != e.cyc) begin
          fails++;
          $display("FAIL write: got A=%0d D=%h cyc=%0d, required A=%0d D=%h cyc=%0d",
                   RB2_A, RB2_D, cyc, e.addr, e.data, e.cyc);
        end
        mem[RB2_A] = RB2_D;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Called at posedge+1. Sends nbits with sen low, then one idle gap cycle.
  task automatic send_frame(input logic [2:0] a, input logic [17:0] d,
                            input int nbits, input bit expect_wr);
    logic [20:0] f;
    f = {a, d};
    for (int i = 0; i < nbits; i++) begin
      sen = 1'b0;
      sd  = (i < 21) ? f[20 - i] : i[0];
      @(posedge clk); #1;
      if (i == 20 && expect_wr) begin
        exp_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = cyc;
        sb.push_back(e);
      end
    end
    sen = 1'b1;
    sd  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rw"},   {31'd0, RB2_RW},  32'd1);
    check({tag, "_a"},    {29'd0, RB2_A},   32'd0);
    check({tag, "_d"},    {14'd0, RB2_D},   32'd0);
    check({tag, "_done"}, {31'd0, S2_done}, 32'd0);
  endtask

  initial begin
    RB2_Q = 18'h0;
    rst   = 1'b1;
    sen   = 1'b1;
    sd    = 1'b0;
    for (int k = 0; k < 8; k++) mem[k] = 18'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_vals("reset");

    // Single frame, address 5.
    send_frame(3'd5, 18'h20001, 21, 1'b1);
    check("hold_a", {29'd0, RB2_A}, 32'd5);
    check("hold_d", {14'd0, RB2_D}, 32'h20001);

    // Truncated frame: no write, then a normal frame.
    send_frame(3'd2, 18'h0F0F0, 10, 1'b0);
    send_frame(3'd2, 18'h15555, 21, 1'b1);

    // Over-length frame: only the first 21 bits count.
    send_frame(3'd6, 18'h0ABCD, 25, 1'b1);
    check("done_after_3", {31'd0, S2_done}, 32'd0);

    // Fourth frame aborted by reset after 11 bits.
    for (int i = 0; i < 11; i++) begin
      sen = 1'b0;
      sd  = i[0];
      @(posedge clk); #1;
    end
    rst = 1'b1;
    sen = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("midreset");
    @(posedge clk); #1;

    // Eight frames from a clean start.
    for (int k = 0; k < 8; k++) begin
      send_frame(3'(k), 18'h3FFFF >> k, 21, 1'b1);
      if (k == 6) check("done_after_7", {31'd0, S2_done}, 32'd0);
    end
    check("done_after_8", {31'd0, S2_done}, 32'd1);
    for (int k = 0; k < 8; k++)
      check($sformatf("mem%0d", k), {14'd0, mem[k]}, {14'd0, 18'h3FFFF >> k});

    // Ninth frame is ignored.
    send_frame(3'd1, 18'h12345, 21, 1'b0);
    repeat (2) @(posedge clk); #1;
    check("done_sticky", {31'd0, S2_done}, 32'd1);
    check("final_a", {29'd0, RB2_A}, 32'd7);
    check("final_d", {14'd0, RB2_D}, 32'h007FF);
    check("final_rw", {31'd0, RB2_RW}, 32'd1);
    check("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_s2
`default_nettype wire

// File: doc/s2.md
S2 -- requirements
Module: s2

Interface
REQ-001 Parameter DATA_W, 18, payload bits per frame and RB2 word width.
REQ-002 Parameter ADDR_W, 3, frame address bits and RB2 address width.
REQ-003 Parameter FRAMES, 8, number of frames to store before done.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 sen  input  1  serial enable; 0 = sd valid this cycle, 1 = idle/frame gap.
REQ-007 sd  input  1  serial data; sampled on rising clk edges where sen==0.
REQ-008 RB2_RW  output  1  RB2 control; 1 = read/idle, 0 = write this cycle.
REQ-009 RB2_A  output  ADDR_W  RB2 address.
REQ-010 RB2_D  output  DATA_W  RB2 write data.
REQ-011 RB2_Q  input  DATA_W  RB2 read data; unused, ignored.
REQ-012 S2_done  output  1  high once FRAMES frames have been written.

Function
REQ-013 Frame = ADDR_W+DATA_W (21) consecutive sampled bits with sen==0: 3 address bits MSB first, then 18 data bits MSB first (first data bit -> RB2_D[17]).
REQ-014 States: IDLE, RECV, WRITE, FLUSH, DONE.
REQ-015 IDLE: on sampled sen==0, capture first bit, bit counter = 1, go RECV; else stay.
REQ-016 RECV: each sampled sen==0 shifts sd into 21-bit shift register, counter +1; when the 21st bit is captured, go WRITE next cycle.
REQ-017 RECV: sen==1 with counter < 21 = short frame; discard, no write, frame count unchanged, go IDLE.
REQ-018 WRITE: exactly one cycle with RB2_RW=0, RB2_A = captured address, RB2_D = captured data; frame counter +1.
REQ-019 After WRITE: if frame counter == FRAMES go DONE; else if sen==1 go IDLE, else go FLUSH.
REQ-020 FLUSH: ignore sd while sen==0 (over-length bits dropped); on sen==1 go IDLE.
REQ-021 Write latency: RB2_RW low in the cycle immediately after the edge sampling the 21st bit.
REQ-022 Frames accepted in any address order; repeated address overwrites; every complete frame counts toward FRAMES.
REQ-023 DONE: S2_done=1, RB2_RW=1, all serial input ignored until reset.
REQ-024 RB2_RW=1 in every state except WRITE; RB2_A/RB2_D hold last written values outside WRITE.
REQ-025 Frame counter width ceil(log2(FRAMES+1)); bit counter 5 bits, saturates at 21.
REQ-026 A minimum 1-cycle sen==1 gap between frames is sufficient; back-to-back frame after WRITE from IDLE is accepted.

Reset
REQ-027 rst high at a rising edge: state=IDLE, RB2_RW=1, RB2_A=0, RB2_D=0, S2_done=0, counters=0, shift register=0.
REQ-028 rst mid-frame or in WRITE/DONE aborts immediately; no write in the cycle after reset; partial frame lost.

Structure
REQ-029 Shared package s2_pkg holds state enum, DATA_W/ADDR_W/FRAMES defaults, FRAME_BITS = ADDR_W+DATA_W.
REQ-030 One sub-module s2_deser: shift register plus bit counter, outputs frame_full and captured addr/data; FSM and RB2 drive stay in s2.

Verification
REQ-031 Eight well-formed frames, addr 0..7, data 18'h3FFFF>>addr, 1-cycle gaps -> eight writes, RB2[k] correct, S2_done=1 cycle after 8th write.
REQ-032 Frame addr 3'b101 data 18'h20001 -> RB2_RW=0 for exactly one cycle with RB2_A=5, RB2_D=18'h20001.
REQ-033 Frame truncated after 10 bits (sen rises) -> no write, frame count unchanged; next full frame writes normally.
REQ-034 Frame with 25 bits sen low -> single write of first 21 bits; extra 4 bits ignored.
REQ-035 rst asserted at bit 12 of frame 4 -> all outputs to reset values; resend 8 frames -> S2_done after 8 writes.
REQ-036 After S2_done, send a ninth frame -> no write, S2_done stays 1.
